masked_accumulator: RTL and testbench
=====================================

# masked_accumulator

Versat functional unit that consumes the all-ones/all-zeros mask stream produced by comparator units (such as the integer greater-than unit) and applies it to a data stream. Over a configured window it accumulates the data samples whose mask is non-zero and counts them. It sits downstream of a comparator in the datapath: data on `in0`, mask on `in1`. It exposes the running sum, the selected-sample count and a window-done flag.

## Interface
Parameters:
- `DATA_W`, 32, width of data, mask and sum.
- `CNT_W`, 16, width of the delay, length and count fields.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `running`  in  1  Versat global enable; when low, all state holds.
- `run`  in  1  one-cycle start pulse for a new window.
- `in0`  in  DATA_W  data sample.
- `in1`  in  DATA_W  mask; any non-zero value selects the sample.
- `delay`  in  CNT_W  cycles to wait after `run` before sampling, for pipeline alignment.
- `length`  in  CNT_W  samples per window.
- `out0`  out  DATA_W  accumulated sum; `versat_latency = 1`.
- `out1`  out  CNT_W  number of selected samples.
- `out2`  out  1  window done.

## Operation
States are IDLE, WAIT, ACCUM and HOLD. The reset state is IDLE.

- **Reset:** `out0`=0, `out1`=0, `out2`=0; the delay counter and sample counter are 0.
- **`run` while `running`=1, in any state:**
  - Latch `delay` and `length`.
  - Clear `out0`, `out1` and `out2`.
  - Go to WAIT, or to ACCUM if `delay`=0.
  - `run` has priority over every other event in the same cycle, including a sample being accepted.
- **`run` while `running`=0:** ignored.
- **WAIT:** decrement the delay counter on each cycle with `running`=1. On reaching 0, go to ACCUM.
- **ACCUM:** on each cycle with `running`=1, one sample is consumed.
  - If `in1`≠0: `out0` ← `out0`+`in0`, and `out1` ← `out1`+1. `out1` saturates at 2^CNT_W−1.
  - If `in1`=0: `out0` and `out1` are unchanged.
  - After the `length`-th sample, go to HOLD and set `out2`=1.
  - A latched `length` of 0 goes straight to HOLD, with `out2`=1 and no samples consumed.
- **HOLD:** outputs are frozen and `out2` stays 1 until the next `run`.
- **`running`=0 in any state:** the FSM, all counters and all outputs hold. There is no sample consumption.
- **Arithmetic (default):** unsigned, modulo 2^DATA_W. Wrap-around is silent.

## Timing
- Latency is 1 cycle. A sample present on `in0`/`in1` in ACCUM cycle *t* is reflected on `out0`/`out1` after edge *t*+1.
- The first sample is taken `delay`+1 cycles after the `run` edge, counting only cycles with `running`=1. With `delay`=0 it is the cycle right after `run`.
- `out2` rises on the same edge that registers the last sample's contribution.
- Asynchronous reset mid-window aborts immediately to IDLE with all outputs 0. No partial result is retained.

## Configuration
Macro: `MASKED_ACCUMULATOR_SAT_EN`.
- **Defined:** `in0` and `out0` are two's-complement signed. The add saturates to 2^(DATA_W−1)−1 on positive overflow and to −2^(DATA_W−1) on negative overflow.
- **Undefined:** the add is unsigned and wraps modulo 2^DATA_W.
- `out1`, `out2` and the FSM are identical in both builds.

## Structure
- **Package `masked_accumulator_pkg`:**
  - State enum typedef with IDLE/WAIT/ACCUM/HOLD.
  - Default `DATA_W`/`CNT_W` constants.
  - A saturation-limit function of width.
- **Sub-module `acc_adder`:**
  - Combinational add of the current sum and the sample.
  - Wrap or saturate selected by `MASKED_ACCUMULATOR_SAT_EN`.
  - Instantiated once.
- **Top level:** FSM, delay counter, sample counter, output registers.

## Test plan
- **Basic masking:** reset, `run`, `delay`=0, `length`=4; `in0`=1,2,3,4, `in1`=FFFFFFFF,0,FFFFFFFF,0 -> `out0`=4, `out1`=2, `out2`=1 one cycle after the 4th sample.
- **Delay alignment:** `delay`=3, `length`=2; `in0`=10 during the 3 delay cycles, then 5,6 with all-ones masks -> `out0`=11, `out1`=2. Samples during the delay are not summed.
- **Pause:** `length`=3, all masks set, `in0`=7; drop `running` for 2 cycles mid-window with `in0`=100 -> `out0`=21, `out1`=3, and `out2` is delayed by 2 cycles.
- **Overflow:**
  - Build without the macro: `in0`=FFFFFFFF,2 selected -> `out0`=1.
  - Build with the macro: `in0`=7FFFFFFF,1 -> `out0`=7FFFFFFF; `in0`=80000000,FFFFFFFF -> `out0`=80000000.
- **Restart and `length`=0:**
  - `run` mid-ACCUM with a sample selected in the same cycle -> `out0`=0, `out1`=0, `out2`=0 next cycle.
  - `run` with `length`=0, `delay`=0 -> `out2`=1 next cycle, `out0`=0.
- **Reset mid-window:** assert `rst_n`=0 asynchronously in ACCUM -> all outputs 0 immediately; state is IDLE after release.

Source files
------------

// File: rtl/masked_accumulator_pkg.sv
// Shared types and constants for the masked_accumulator Versat unit.
// Optional saturating arithmetic is enabled with the macro MASKED_ACCUMULATOR_SAT_EN.
package masked_accumulator_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    // Largest positive two's-complement value representable in 'width' bits (width <= 64).
    function automatic logic [63:0] sat_max_pos(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/masked_accumulator_adder.sv
// Combinational sum + sample adder for masked_accumulator.
// Wraps modulo 2^DATA_W by default; saturates signed when MASKED_ACCUMULATOR_SAT_EN is defined.
module acc_adder
    import masked_accumulator_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] i_sum,
    input  logic [DATA_W-1:0] i_sample,
    output logic [DATA_W-1:0] o_sum
);

    logic [DATA_W-1:0] w_raw;

    assign w_raw = i_sum + i_sample;

`ifdef MASKED_ACCUMULATOR_SAT_EN
    localparam logic [63:0]       SAT_MAX64 = sat_max_pos(DATA_W);
    localparam logic [DATA_W-1:0] SAT_MAX   = SAT_MAX64[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SAT_MIN   = ~SAT_MAX;

    logic w_ovf;

    // Signed overflow: both operands share a sign that the raw result does not.
    assign w_ovf = (i_sum[DATA_W-1] == i_sample[DATA_W-1]) &&
                   (w_raw[DATA_W-1] != i_sum[DATA_W-1]);
    assign o_sum = w_ovf ? (i_sum[DATA_W-1] ? SAT_MIN : SAT_MAX) : w_raw;
`else
    assign o_sum = w_raw;
`endif

endmodule

// File: rtl/masked_accumulator.sv
// Masked accumulator: sums data samples whose mask is non-zero over a delayed window.
// Build option MASKED_ACCUMULATOR_SAT_EN selects signed saturating accumulation.
module masked_accumulator
    import masked_accumulator_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              running,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [CNT_W-1:0]  delay,
    input  logic [CNT_W-1:0]  length,
    output logic [DATA_W-1:0] out0,
    output logic [CNT_W-1:0]  out1,
    output logic              out2
);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_delay_cnt;
    logic [CNT_W-1:0]  r_sample_cnt;
    logic [CNT_W-1:0]  r_length;
    logic [DATA_W-1:0] w_sum_next;
    logic              w_start;
    logic              w_select;
    logic              w_last;

    assign w_start  = running & run;
    assign w_select = |in1;
    assign w_last   = (r_sample_cnt == r_length - CNT_W'(1));

    acc_adder #(.DATA_W(DATA_W)) u_adder (
        .i_sum    (out0),
        .i_sample (in0),
        .o_sum    (w_sum_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the next state gets a default first, so no path through the block can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = (delay == '0) ? ST_ACCUM : ST_WAIT;
        end else if (running) begin
            case (r_state)
                ST_WAIT:  if (r_delay_cnt == CNT_W'(1)) w_state_next = ST_ACCUM;
                ST_ACCUM: if (r_length == '0 || w_last) w_state_next = ST_HOLD;
                default:  w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay_cnt  <= '0;
            r_sample_cnt <= '0;
            r_length     <= '0;
            out0         <= '0;
            out1         <= '0;
            out2         <= 1'b0;
        end else if (w_start) begin
            r_delay_cnt  <= delay;
            r_sample_cnt <= '0;
            r_length     <= length;
            out0         <= '0;
            out1         <= '0;
            out2         <= 1'b0;
        end else if (running) begin
            case (r_state)
                ST_WAIT: begin
                    r_delay_cnt <= r_delay_cnt - 1'b1;
                end
                ST_ACCUM: begin
                    // An empty window finishes without consuming a sample.
                    if (r_length == '0) begin
                        out2 <= 1'b1;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + 1'b1;
                        if (w_select) begin
                            out0 <= w_sum_next;
                            if (out1 != '1) out1 <= out1 + 1'b1;
                        end
                        if (w_last) out2 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_masked_accumulator.sv
// Scoreboard testbench for masked_accumulator: windows are modelled arithmetically and
// the expected result is checked by a monitor when the done flag rises.
`timescale 1ns/1ps
module tb_masked_accumulator;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        running = 1'b0;
    logic        run     = 1'b0;
    logic [31:0] in0     = '0;
    logic [31:0] in1     = '0;
    logic [15:0] delay   = '0;
    logic [15:0] length  = '0;
    logic [31:0] out0;
    logic [15:0] out1;
    logic        out2;

    masked_accumulator #(.DATA_W(32), .CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .running (running),
        .run     (run),
        .in0     (in0),
        .in1     (in1),
        .delay   (delay),
        .length  (length),
        .out0    (out0),
        .out1    (out1),
        .out2    (out2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sum;
        logic [15:0] cnt;
        int          done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] q_data[$];
    logic [31:0] q_mask[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
`ifdef MASKED_ACCUMULATOR_SAT_EN
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
`else
        return a + b;
`endif
    endfunction

    // Monitor: each rising edge of the done flag retires one expected window.
    logic prev_out2 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (out2 && !prev_out2) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(out2), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("win_sum", 64'(out0), 64'(e.sum));
                check("win_cnt", 64'(out1), 64'(e.cnt));
                check("win_done_cycle", 64'(cyc), 64'(e.done_cyc));
            end
        end
        prev_out2 = out2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one window from q_data/q_mask; pause_at forces a 2-cycle stall before that sample.
    task automatic window(input logic [15:0] d, input logic [15:0] l, input int pause_pct,
                          input int pause_at, input logic [31:0] noise);
        logic [31:0] sum;
        logic [15:0] cnt;
        int          remaining;
        int          delay_left;
        int          idx;
        int          pause_left;
        bit          forced_done;
        bit          pause;
        sum = '0; cnt = '0; idx = 0; pause_left = 0; forced_done = 0;
        delay_left = int'(d);
        remaining  = int'(d) + ((l == 0) ? 1 : int'(l));
        running = 1'b1; run = 1'b1; delay = d; length = l; in0 = $urandom; in1 = $urandom;
        step();
        run = 1'b0;
        while (remaining > 0) begin
            if (pause_at >= 0 && idx == pause_at && delay_left == 0 && !forced_done) begin
                pause_left  = 2;
                forced_done = 1;
            end
            pause = (pause_left > 0) || ($urandom_range(99) < pause_pct);
            if (pause_left > 0) pause_left--;
            if (pause) begin
                running = 1'b0; in0 = noise; in1 = '1;
            end else begin
                running = 1'b1;
                if (delay_left > 0) begin
                    in0 = noise; in1 = '1; delay_left--;
                end else if (idx < int'(l)) begin
                    in0 = q_data[idx]; in1 = q_mask[idx];
                    if (in1 != 0) begin
                        sum = model_add(sum, in0);
                        if (cnt != 16'hFFFF) cnt++;
                    end
                    idx++;
                end else begin
                    in0 = noise; in1 = '1;
                end
                remaining--;
                if (remaining == 0) sb_q.push_back('{sum: sum, cnt: cnt, done_cyc: cyc + 1});
            end
            step();
        end
        running = 1'b1; in0 = $urandom | 32'h1; in1 = '1;
        step();
        step();
        check("hold_done", 64'(out2), 64'd1);
        check("hold_sum", 64'(out0), 64'(sum));
        check("hold_cnt", 64'(out1), 64'(cnt));
        check("window_retired", 64'(sb_q.size()), 64'd0);
        if (sb_q.size() != 0) sb_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] l;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out0", 64'(out0), 64'd0);
        check("reset_out1", 64'(out1), 64'd0);
        check("reset_out2", 64'(out2), 64'd0);
        rst_n = 1'b1;
        step();

        q_data = '{32'd1, 32'd2, 32'd3, 32'd4};
        q_mask = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0};
        window(16'd0, 16'd4, 0, -1, 32'd0);
        check("basic_sum_literal", 64'(out0), 64'd4);

        q_data = '{32'd5, 32'd6};
        q_mask = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        window(16'd3, 16'd2, 0, -1, 32'd10);
        check("delay_sum_literal", 64'(out0), 64'd11);

        q_data = '{32'd7, 32'd7, 32'd7};
        q_mask = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        window(16'd0, 16'd3, 0, 1, 32'd100);
        check("pause_sum_literal", 64'(out0), 64'd21);

`ifdef MASKED_ACCUMULATOR_SAT_EN
        q_data = '{32'h7FFF_FFFF, 32'd1};
        q_mask = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        window(16'd0, 16'd2, 0, -1, 32'd0);
        check("sat_pos_literal", 64'(out0), 64'h7FFF_FFFF);
        q_data = '{32'h8000_0000, 32'hFFFF_FFFF};
        window(16'd0, 16'd2, 0, -1, 32'd0);
        check("sat_neg_literal", 64'(out0), 64'h8000_0000);
`else
        q_data = '{32'hFFFF_FFFF, 32'd2};
        q_mask = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        window(16'd0, 16'd2, 0, -1, 32'd0);
        check("wrap_literal", 64'(out0), 64'd1);
`endif

        q_data.delete();
        q_mask.delete();
        window(16'd0, 16'd0, 0, -1, 32'd0);
        check("len0_sum_literal", 64'(out0), 64'd0);

        // Restart mid-window with a selected sample on the same edge.
        running = 1'b1; run = 1'b1; delay = 16'd0; length = 16'd10;
        step();
        run = 1'b0; in0 = 32'd5; in1 = '1;
        repeat (3) step();
        run = 1'b1; length = 16'd4; in0 = 32'd9; in1 = '1;
        step();
        run = 1'b0;
        check("restart_out0", 64'(out0), 64'd0);
        check("restart_out1", 64'(out1), 64'd0);
        check("restart_out2", 64'(out2), 64'd0);

        // Asynchronous reset in the middle of an accumulating window.
        running = 1'b1; run = 1'b1; delay = 16'd0; length = 16'd10;
        step();
        run = 1'b0; in0 = 32'd3; in1 = '1;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out0", 64'(out0), 64'd0);
        check("async_rst_out1", 64'(out1), 64'd0);
        check("async_rst_out2", 64'(out2), 64'd0);
        step();
        rst_n = 1'b1;
        in0 = 32'd5; in1 = '1;
        repeat (3) step();
        check("idle_after_rst_out0", 64'(out0), 64'd0);
        check("idle_after_rst_out1", 64'(out1), 64'd0);
        check("idle_after_rst_out2", 64'(out2), 64'd0);

        for (int w = 0; w < 20; w++) begin
            l = 16'($urandom_range(12));
            q_data.delete();
            q_mask.delete();
            for (int i = 0; i < int'(l); i++) begin
                q_data.push_back($urandom);
                q_mask.push_back(($urandom_range(1) == 1) ? ($urandom | 32'h1) : 32'd0);
            end
            window(16'($urandom_range(4)), l, 20, -1, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
